// File: rtl/mem_region_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM among NUM_CH masters, with text/glyph region decode.
// Optional macro MEM_ARB_GLYPH_WPROT_EN write-protects the glyph region.
module mem_region_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 15,
    parameter int NUM_CH     = 3,
    parameter int TEXT_BASE  = 0,
    parameter int TEXT_SIZE  = 8192,
    parameter int GLYPH_BASE = 8192,
    parameter int GLYPH_SIZE = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_gnt,
    output logic [NUM_CH-1:0]        ch_rvalid,
    output logic [NUM_CH-1:0]        ch_err,
    output logic [DATA_W-1:0]        rdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_we,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int PTR_W = $clog2(NUM_CH);
    localparam logic [ADDR_W:0] TEXT_LO  = (ADDR_W+1)'(TEXT_BASE);
    localparam logic [ADDR_W:0] RANGE_SZ = (ADDR_W+1)'(TEXT_SIZE + GLYPH_SIZE);

    logic [PTR_W-1:0]  r_ptr;
    logic              r_cvld;
    logic [PTR_W-1:0]  r_cch;
    logic              r_cerr;
    logic              r_crd;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [DATA_W-1:0] r_wdata_hold;

    logic [PTR_W:0]    w_pick;
    logic              w_any;
    logic [PTR_W-1:0]  w_win;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic [ADDR_W-1:0] w_addr_sel;
    logic [DATA_W-1:0] w_wdata_sel;
    logic              w_we_sel;
    logic [ADDR_W:0]   w_addr_ext;
    logic              w_in_range;
    logic              w_permit;
    logic              w_err;

    // First requester at or after the pointer, wrapping; lowest offset wins.
    function automatic logic [PTR_W:0] f_rr_pick(input logic [NUM_CH-1:0] req,
                                                 input logic [PTR_W-1:0]  ptr);
        logic [PTR_W:0] res;
        int idx;
        res = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (req[idx]) res = {1'b1, PTR_W'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        w_pick      = f_rr_pick(ch_req, r_ptr);
        // Arbitration is held off while reset is asserted so every output reads zero.
        w_any       = w_pick[PTR_W] & reset;
        w_win       = w_pick[PTR_W-1:0];
        w_ptr_nxt   = (w_win == PTR_W'(NUM_CH - 1)) ? '0 : w_win + 1'b1;
        w_addr_sel  = ch_addr[w_win*ADDR_W +: ADDR_W];
        w_wdata_sel = ch_wdata[w_win*DATA_W +: DATA_W];
        w_we_sel    = ch_we[w_win];
        w_addr_ext  = {1'b0, w_addr_sel};
        // Offset compare at ADDR_W+1 bits: addresses below the base wrap to huge offsets.
        w_in_range  = (w_addr_ext - TEXT_LO) < RANGE_SZ;
`ifdef MEM_ARB_GLYPH_WPROT_EN
        w_permit    = !(w_we_sel &&
                        ((w_addr_ext - (ADDR_W+1)'(GLYPH_BASE)) < (ADDR_W+1)'(GLYPH_SIZE)));
`else
        w_permit    = 1'b1;
`endif
        w_err       = !w_in_range | !w_permit;
    end

    always_comb begin
        ch_gnt    = w_any ? (NUM_CH'(1) << w_win) : '0;
        mem_we    = w_any & w_we_sel & w_in_range & w_permit;
        mem_addr  = w_any ? w_addr_sel  : r_addr_hold;
        mem_wdata = w_any ? w_wdata_sel : r_wdata_hold;
        ch_rvalid = r_cvld ? (NUM_CH'(1) << r_cch) : '0;
        ch_err    = r_cerr ? ch_rvalid : '0;
        rdata     = (r_cvld & r_crd) ? mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr        <= '0;
            r_cvld       <= 1'b0;
            r_cch        <= '0;
            r_cerr       <= 1'b0;
            r_crd        <= 1'b0;
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
        end else begin
            r_cvld <= w_any;
            if (w_any) begin
                r_ptr        <= w_ptr_nxt;
                r_cch        <= w_win;
                r_cerr       <= w_err;
                r_crd        <= !w_we_sel & w_in_range;
                r_addr_hold  <= w_addr_sel;
                r_wdata_hold <= w_wdata_sel;
            end
        end
    end

endmodule

// File: tb/tb_mem_region_arbiter.sv
// Directed self-checking bench for mem_region_arbiter (NUM_CH=3) with a behavioural 1-cycle-latency RAM.
module tb_mem_region_arbiter;
    localparam int DW = 16;
    localparam int AW = 15;
    localparam int NC = 3;

    logic             clk;
    logic             reset;
    logic [NC-1:0]    ch_req;
    logic [NC-1:0]    ch_we;
    logic [NC*AW-1:0] ch_addr;
    logic [NC*DW-1:0] ch_wdata;
    logic [NC-1:0]    ch_gnt;
    logic [NC-1:0]    ch_rvalid;
    logic [NC-1:0]    ch_err;
    logic [DW-1:0]    rdata;
    logic [AW-1:0]    mem_addr;
    logic             mem_we;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    mem_region_arbiter dut (
        .clk(clk), .reset(reset),
        .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_gnt(ch_gnt), .ch_rvalid(ch_rvalid), .ch_err(ch_err), .rdata(rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic set_ch(input int ch, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ch_we[ch] = we;
        ch_addr[ch*AW +: AW] = a;
        ch_wdata[ch*DW +: DW] = d;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        preload(15'h0001, 16'h1111);
        preload(15'h0002, 16'h2222);
        preload(15'h0003, 16'h3333);
        preload(15'h0010, 16'h0000);
        preload(15'h23FF, 16'h5A5A);
        preload(15'h2005, 16'h0F0F);
        @(negedge clk);
        checks++;
        if ({ch_gnt, ch_rvalid, ch_err, mem_we, mem_addr, mem_wdata, rdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs gnt=%b rvalid=%b err=%b we=%b addr=%h wdata=%h rdata=%h (all required 0)",
                     ch_gnt, ch_rvalid, ch_err, mem_we, mem_addr, mem_wdata, rdata);
        end
        reset = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [NC-1:0] exp_gnt [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000, 3'b000};
        logic [NC-1:0] exp_rv  [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b000};
        logic [DW-1:0] exp_rd  [6] = '{16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h1111, 16'h0000};
        set_ch(0, 1'b0, 15'h0001, 16'h0);
        set_ch(1, 1'b0, 15'h0002, 16'h0);
        set_ch(2, 1'b0, 15'h0003, 16'h0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            ch_req = (c < 4) ? 3'b111 : 3'b000;
            @(negedge clk);
            checks++;
            if (ch_gnt !== exp_gnt[c]) begin
                failures++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", c, ch_gnt, exp_gnt[c]);
            end
            checks++;
            if (ch_rvalid !== exp_rv[c]) begin
                failures++; $display("FAIL rr_rvalid[%0d] got=%b exp=%b", c, ch_rvalid, exp_rv[c]);
            end
            checks++;
            if (rdata !== exp_rd[c]) begin
                failures++; $display("FAIL rr_rdata[%0d] got=%h exp=%h", c, rdata, exp_rd[c]);
            end
            checks++;
            if ({ch_err, mem_we} !== 4'b0) begin
                failures++; $display("FAIL rr_err_we[%0d] got err=%b we=%b exp 0", c, ch_err, mem_we);
            end
        end
    endtask

    task automatic test_write_read();
        @(posedge clk); #1;
        set_ch(1, 1'b1, 15'h0010, 16'hBEEF);
        ch_req = 3'b010;
        @(negedge clk);
        checks++;
        if ({ch_gnt, mem_we, mem_addr, mem_wdata} !== {3'b010, 1'b1, 15'h0010, 16'hBEEF}) begin
            failures++;
            $display("FAIL wr_grant got gnt=%b we=%b addr=%h wdata=%h exp gnt=010 we=1 addr=0010 wdata=beef",
                     ch_gnt, mem_we, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        set_ch(2, 1'b0, 15'h0010, 16'h0);
        ch_req = 3'b100;
        @(negedge clk);
        checks++;
        if ({ch_gnt, mem_we, ch_rvalid, ch_err, rdata} !== {3'b100, 1'b0, 3'b010, 3'b000, 16'h0}) begin
            failures++;
            $display("FAIL wr_ack got gnt=%b we=%b rvalid=%b err=%b rdata=%h exp gnt=100 we=0 rvalid=010 err=000 rdata=0000",
                     ch_gnt, mem_we, ch_rvalid, ch_err, rdata);
        end
        @(posedge clk); #1;
        ch_req = 3'b000;
        @(negedge clk);
        checks++;
        if ({ch_rvalid, ch_err, rdata} !== {3'b100, 3'b000, 16'hBEEF}) begin
            failures++;
            $display("FAIL rd_back got rvalid=%b err=%b rdata=%h exp rvalid=100 err=000 rdata=beef",
                     ch_rvalid, ch_err, rdata);
        end
    endtask

    task automatic test_out_of_range();
        logic          we_v [3] = '{1'b0, 1'b1, 1'b0};
        logic [AW-1:0] ad_v [3] = '{15'h2400, 15'h7FFF, 15'h23FF};
        logic [NC-1:0] er_v [3] = '{3'b001, 3'b001, 3'b000};
        logic [DW-1:0] rd_v [3] = '{16'h0000, 16'h0000, 16'h5A5A};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            set_ch(0, we_v[i], ad_v[i], 16'hAAAA);
            ch_req = 3'b001;
            @(negedge clk);
            checks++;
            if ({ch_gnt, mem_we} !== {3'b001, 1'b0}) begin
                failures++;
                $display("FAIL oor_grant[%0d] got gnt=%b we=%b exp gnt=001 we=0", i, ch_gnt, mem_we);
            end
            @(posedge clk); #1;
            ch_req = 3'b000;
            @(negedge clk);
            checks++;
            if ({ch_rvalid, ch_err, rdata} !== {3'b001, er_v[i], rd_v[i]}) begin
                failures++;
                $display("FAIL oor_done[%0d] got rvalid=%b err=%b rdata=%h exp rvalid=001 err=%b rdata=%h",
                         i, ch_rvalid, ch_err, rdata, er_v[i], rd_v[i]);
            end
        end
    endtask

    task automatic test_glyph_write();
        logic          exp_we;
        logic [NC-1:0] exp_err;
        logic [DW-1:0] exp_rd;
`ifdef MEM_ARB_GLYPH_WPROT_EN
        exp_we = 1'b0; exp_err = 3'b001; exp_rd = 16'h0F0F;
`else
        exp_we = 1'b1; exp_err = 3'b000; exp_rd = 16'h1234;
`endif
        @(posedge clk); #1;
        set_ch(0, 1'b1, 15'h2005, 16'h1234);
        ch_req = 3'b001;
        @(negedge clk);
        checks++;
        if ({ch_gnt, mem_we} !== {3'b001, exp_we}) begin
            failures++; $display("FAIL glyph_wr got gnt=%b we=%b exp gnt=001 we=%b", ch_gnt, mem_we, exp_we);
        end
        @(posedge clk); #1;
        set_ch(0, 1'b0, 15'h2005, 16'h0);
        @(negedge clk);
        checks++;
        if ({ch_gnt, ch_rvalid, ch_err} !== {3'b001, 3'b001, exp_err}) begin
            failures++;
            $display("FAIL glyph_ack got gnt=%b rvalid=%b err=%b exp gnt=001 rvalid=001 err=%b",
                     ch_gnt, ch_rvalid, ch_err, exp_err);
        end
        @(posedge clk); #1;
        ch_req = 3'b000;
        @(negedge clk);
        checks++;
        if ({ch_rvalid, ch_err, rdata} !== {3'b001, 3'b000, exp_rd}) begin
            failures++;
            $display("FAIL glyph_rd got rvalid=%b err=%b rdata=%h exp rvalid=001 err=000 rdata=%h",
                     ch_rvalid, ch_err, rdata, exp_rd);
        end
    endtask

    task automatic test_back_to_back();
        set_ch(0, 1'b0, 15'h0001, 16'h0);
        set_ch(1, 1'b0, 15'h0002, 16'h0);
        set_ch(2, 1'b0, 15'h0003, 16'h0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            ch_req = (c < 4) ? 3'b100 : 3'b000;
            @(negedge clk);
            checks++;
            if (ch_gnt !== ((c < 4) ? 3'b100 : 3'b000)) begin
                failures++; $display("FAIL b2b_gnt[%0d] got=%b exp=%b", c, ch_gnt, (c < 4) ? 3'b100 : 3'b000);
            end
            checks++;
            if ({ch_rvalid, rdata} !== ((c > 0) ? {3'b100, 16'h3333} : {3'b000, 16'h0})) begin
                failures++; $display("FAIL b2b_rvalid[%0d] got rvalid=%b rdata=%h", c, ch_rvalid, rdata);
            end
        end
        @(posedge clk); #1;
        ch_req = 3'b111;
        @(negedge clk);
        checks++;
        if (ch_gnt !== 3'b001) begin
            failures++; $display("FAIL b2b_ptr_wrap got gnt=%b exp=001", ch_gnt);
        end
        @(posedge clk); #1;
        ch_req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        ch_req = 3'b010;
        @(negedge clk);
        checks++;
        if (ch_gnt !== 3'b010) begin
            failures++; $display("FAIL rstmid_gnt got=%b exp=010", ch_gnt);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        ch_req = 3'b111;
        #1;
        checks++;
        if ({ch_gnt, ch_rvalid, ch_err, mem_we, mem_addr, mem_wdata, rdata} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs gnt=%b rvalid=%b err=%b we=%b addr=%h wdata=%h rdata=%h (all required 0)",
                     ch_gnt, ch_rvalid, ch_err, mem_we, mem_addr, mem_wdata, rdata);
        end
        ch_req = 3'b000;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (ch_rvalid !== 3'b000) begin
            failures++; $display("FAIL rstmid_no_rvalid got=%b exp=000", ch_rvalid);
        end
        @(posedge clk); #1;
        ch_req = 3'b111;
        @(negedge clk);
        checks++;
        if (ch_gnt !== 3'b001) begin
            failures++; $display("FAIL rstmid_first_gnt got=%b exp=001", ch_gnt);
        end
        @(posedge clk); #1;
        ch_req = 3'b000;
        @(negedge clk);
        checks++;
        if ({ch_rvalid, rdata} !== {3'b001, 16'h1111}) begin
            failures++; $display("FAIL rstmid_first_done got rvalid=%b rdata=%h exp rvalid=001 rdata=1111", ch_rvalid, rdata);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_write_read();
        test_out_of_range();
        test_glyph_write();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
